// File: rtl/mem_arb.sv
// mem_arb: two-port arbiter in front of a single-ported synchronous RAM.
// Port 1 (data) normally wins over port 0 (instruction fetch). A starvation
// counter forces a port 0 grant once it has lost STARVE_LIMIT cycles in a row.
// Grants are combinational: the access is issued to the RAM in the same cycle.
// A small FSM remembers which port owns the read returning in the next cycle.
module mem_arb #(
  parameter int ADDR_WIDTH   = 32,
  parameter int WORD_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [WORD_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [WORD_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [WORD_WIDTH-1:0] m1_rdata,
  output logic                  ram_wen,
  output logic                  ram_ren,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [WORD_WIDTH-1:0] ram_wdata,
  input  logic [WORD_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, RD0, RD1} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic [15:0] gnt0_cnt;
  logic [15:0] gnt1_cnt;
  logic        force0;
  logic        gnt0;
  logic        gnt1;
  logic        rd1;
  logic        wr1;

  // Arbitration: port 1 first unless port 0 has hit its starvation limit.
  // Reset masks every grant so nothing reaches the RAM while it is held.
  always_comb begin
    force0 = m0_req && (starve_cnt == LIMIT);
    gnt0   = !reset && m0_req && (force0 || !m1_req);
    gnt1   = !reset && m1_req && !force0;
    rd1    = gnt1 && !m1_we;
    wr1    = gnt1 && m1_we;
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  // RAM command mux; all address/data lines idle at zero without a grant.
  always_comb begin
    ram_ren   = gnt0 || rd1;
    ram_wen   = wr1;
    ram_raddr = '0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (gnt0) begin
      ram_raddr = m0_addr;
    end else if (rd1) begin
      ram_raddr = m1_addr;
    end
    if (wr1) begin
      ram_waddr = m1_addr;
      ram_wdata = m1_wdata;
    end
  end

  // Pending-read FSM: records which port owns the data the RAM returns next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (gnt0) begin
      state <= RD0;
    end else if (rd1) begin
      state <= RD1;
    end else begin
      state <= IDLE;
    end
  end

  // Read-return steering; data lines are zero when the port has no valid.
  always_comb begin
    m0_rvalid = (state == RD0);
    m1_rvalid = (state == RD1);
    m0_rdata  = m0_rvalid ? ram_rdata : '0;
    m1_rdata  = m1_rvalid ? ram_rdata : '0;
  end

  // Starvation counter: counts consecutive cycles port 0 waits while requesting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (m0_req && !gnt0) begin
      starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  // Saturating per-port grant counters for debug visibility.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt0_cnt <= 16'd0;
      gnt1_cnt <= 16'd0;
    end else begin
      if (gnt0 && (gnt0_cnt != 16'hFFFF)) begin
        gnt0_cnt <= gnt0_cnt + 16'd1;
      end
      if (gnt1 && (gnt1_cnt != 16'hFFFF)) begin
        gnt1_cnt <= gnt1_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed scenarios for mem_arb with a small behavioural RAM.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_mem_arb;

  logic        clk;
  logic        reset;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        ram_wen;
  logic        ram_ren;
  logic [31:0] ram_waddr;
  logic [31:0] ram_raddr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:255];

  int checks;
  int passes;

  mem_arb #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_waddr(ram_waddr),
    .ram_raddr(ram_raddr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model: one-cycle registered read.
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr[7:0]] <= ram_wdata;
    if (ram_ren) ram_rdata <= mem[ram_raddr[7:0]];
  end

  task automatic idle_inputs();
    m0_req = 1'b0; m0_addr = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    m0_req = 1'b1; m1_req = 1'b1;
    @(negedge clk); #1;
    $display("txn reset held with both requests");
    checks++; if (m0_gnt !== 1'b0) $display("FAIL rst_m0_gnt got %0b want 0", m0_gnt); else passes++;
    checks++; if (m1_gnt !== 1'b0) $display("FAIL rst_m1_gnt got %0b want 0", m1_gnt); else passes++;
    checks++; if ({ram_wen, ram_ren} !== 2'b00) $display("FAIL rst_ram_en got %b want 00", {ram_wen, ram_ren}); else passes++;
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) $display("FAIL rst_rvalid got %b want 00", {m0_rvalid, m1_rvalid}); else passes++;
    checks++; if (dut.starve_cnt !== 4'd0) $display("FAIL rst_starve got %0d want 0", dut.starve_cnt); else passes++;
    checks++; if (dut.gnt0_cnt !== 16'd0) $display("FAIL rst_gnt0_cnt got %0d want 0", dut.gnt0_cnt); else passes++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    $display("txn first arbitration after reset");
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) $display("FAIL first_gnt got %b want 01", {m0_gnt, m1_gnt}); else passes++;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_port0_read();
    // Preload 0x10 through port 1, then read it back on port 0 only.
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10; m1_wdata = 32'hDEADBEEF;
    #1;
    $display("txn p1 write 0x10 <- 0xdeadbeef");
    checks++; if ({ram_wen, ram_ren} !== 2'b10) $display("FAIL pre_wr_en got %b want 10", {ram_wen, ram_ren}); else passes++;
    @(negedge clk);
    idle_inputs();
    m0_req = 1'b1; m0_addr = 32'h10;
    #1;
    $display("txn p0 read 0x10");
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL p0_gnt got %b want 10", {m0_gnt, m1_gnt}); else passes++;
    checks++; if (ram_raddr !== 32'h10 || ram_ren !== 1'b1) $display("FAIL p0_raddr got %h/%0b want 10/1", ram_raddr, ram_ren); else passes++;
    checks++; if (m1_rvalid !== 1'b0) $display("FAIL pre_wr_rvalid got %0b want 0", m1_rvalid); else passes++;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (m0_rvalid !== 1'b1) $display("FAIL p0_rvalid got %0b want 1", m0_rvalid); else passes++;
    checks++; if (m0_rdata !== 32'hDEADBEEF) $display("FAIL p0_rdata got %h want deadbeef", m0_rdata); else passes++;
    checks++; if ({m1_gnt, m1_rvalid} !== 2'b00 || m1_rdata !== 32'h0) $display("FAIL p0_m1_quiet got %b/%h want 00/0", {m1_gnt, m1_rvalid}, m1_rdata); else passes++;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    #1;
    $display("txn p1 write 0x20 <- 0x12345678");
    checks++; if ({m1_gnt, ram_wen, ram_ren} !== 3'b110) $display("FAIL wr_en got %b want 110", {m1_gnt, ram_wen, ram_ren}); else passes++;
    checks++; if (ram_waddr !== 32'h20 || ram_wdata !== 32'h12345678) $display("FAIL wr_bus got %h/%h want 20/12345678", ram_waddr, ram_wdata); else passes++;
    checks++; if (ram_raddr !== 32'h0) $display("FAIL wr_raddr_idle got %h want 0", ram_raddr); else passes++;
    @(negedge clk);
    m1_we = 1'b0;
    #1;
    $display("txn p1 read 0x20");
    checks++; if (m1_rvalid !== 1'b0) $display("FAIL wr_no_rvalid got %0b want 0", m1_rvalid); else passes++;
    checks++; if ({m1_gnt, ram_wen, ram_ren} !== 3'b101 || ram_raddr !== 32'h20) $display("FAIL rd_en got %b/%h want 101/20", {m1_gnt, ram_wen, ram_ren}, ram_raddr); else passes++;
    checks++; if (ram_waddr !== 32'h0 || ram_wdata !== 32'h0) $display("FAIL rd_wbus_idle got %h/%h want 0/0", ram_waddr, ram_wdata); else passes++;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h12345678) $display("FAIL rd_data got %0b/%h want 1/12345678", m1_rvalid, m1_rdata); else passes++;
    checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) $display("FAIL rd_m0_quiet got %0b/%h want 0/0", m0_rvalid, m0_rdata); else passes++;
    @(negedge clk);
  endtask

  task automatic test_starve();
    logic exp0;
    logic prev0;
    prev0 = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp0 = ((i % 5) == 4);
      $display("txn contention cycle %0d", i);
      checks++; if ({m0_gnt, m1_gnt} !== {exp0, ~exp0}) $display("FAIL starve_gnt_%0d got %b want %b", i, {m0_gnt, m1_gnt}, {exp0, ~exp0}); else passes++;
      checks++; if ((ram_wen & ram_ren) !== 1'b0) $display("FAIL starve_excl_%0d got wen=%0b ren=%0b want not both", i, ram_wen, ram_ren); else passes++;
      if (i > 0) begin
        checks++; if ({m0_rvalid, m1_rvalid} !== {prev0, ~prev0}) $display("FAIL starve_rvalid_%0d got %b want %b", i, {m0_rvalid, m1_rvalid}, {prev0, ~prev0}); else passes++;
        checks++; if ((m0_rdata | m1_rdata) !== (prev0 ? 32'hDEADBEEF : 32'h12345678)) $display("FAIL starve_rdata_%0d got %h/%h want port %0d data", i, m0_rdata, m1_rdata, prev0 ? 0 : 1); else passes++;
      end
      prev0 = exp0;
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    m0_req = 1'b1; m0_addr = 32'h10;
    #1;
    $display("txn b2b p0 read 0x10");
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL b2b_g0 got %b want 10", {m0_gnt, m1_gnt}); else passes++;
    @(negedge clk);
    idle_inputs();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    #1;
    $display("txn b2b p1 read 0x20");
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) $display("FAIL b2b_g1 got %b want 01", {m0_gnt, m1_gnt}); else passes++;
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rdata !== 32'hDEADBEEF) $display("FAIL b2b_rv0 got %b/%h want 10/deadbeef", {m0_rvalid, m1_rvalid}, m0_rdata); else passes++;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 32'h12345678) $display("FAIL b2b_rv1 got %b/%h want 01/12345678", {m0_rvalid, m1_rvalid}, m1_rdata); else passes++;
    @(negedge clk);
    #1;
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) $display("FAIL b2b_done got %b want 00", {m0_rvalid, m1_rvalid}); else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    m0_req = 1'b1; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    #1;
    $display("txn p1 read then reset mid-cycle");
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) $display("FAIL mid_gnt got %b want 01", {m0_gnt, m1_gnt}); else passes++;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) $display("FAIL mid_rvalid got %0b/%h want 0/0", m1_rvalid, m1_rdata); else passes++;
    checks++; if ({m0_gnt, m1_gnt, ram_wen, ram_ren} !== 4'b0000) $display("FAIL mid_outs got %b want 0000", {m0_gnt, m1_gnt, ram_wen, ram_ren}); else passes++;
    checks++; if (dut.starve_cnt !== 4'd0) $display("FAIL mid_starve got %0d want 0", dut.starve_cnt); else passes++;
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) $display("FAIL mid_release got %b want 00", {m0_rvalid, m1_rvalid}); else passes++;
    @(negedge clk);
    #1;
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) $display("FAIL mid_after got %b want 00", {m0_rvalid, m1_rvalid}); else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_port0_read();
    test_write_read();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- ADDR_WIDTH, 32, address width
- WORD_WIDTH, 32, data width
- STARVE_LIMIT, 4, consecutive lost cycles after which port 0 wins (range 1-15)

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  port 0 (instruction fetch) read request
- m0_addr  in  ADDR_WIDTH  port 0 read address
- m0_gnt  out  1  port 0 request accepted this cycle
- m0_rvalid  out  1  port 0 read data valid
- m0_rdata  out  WORD_WIDTH  port 0 read data
- m1_req  in  1  port 1 (data memory) request
- m1_we  in  1  port 1 write (1) or read (0)
- m1_addr  in  ADDR_WIDTH  port 1 address
- m1_wdata  in  WORD_WIDTH  port 1 write data
- m1_gnt  out  1  port 1 request accepted this cycle
- m1_rvalid  out  1  port 1 read data valid
- m1_rdata  out  WORD_WIDTH  port 1 read data
- ram_wen, ram_ren  out  1  RAM write/read enables
- ram_waddr, ram_raddr  out  ADDR_WIDTH  RAM addresses
- ram_wdata  out  WORD_WIDTH  RAM write data
- ram_rdata  in  WORD_WIDTH  RAM read data, registered by RAM, valid 1 cycle after ren

Function
REQ-003 At most one access SHALL be issued to the RAM per cycle; ram_wen and ram_ren SHALL never both be 1.
REQ-004 Grant SHALL be combinational from the current requests and starve count; mX_gnt=1 means the access is issued to the RAM in that same cycle.
REQ-005 Default priority SHALL be port 1 over port 0.
REQ-006 starve_cnt (4 bits) SHALL increment each cycle m0_req=1 and m0_gnt=0, and SHALL clear on m0_gnt=1 or when m0_req=0.
REQ-007 When starve_cnt==STARVE_LIMIT and m0_req=1, port 0 SHALL be granted regardless of m1_req.
REQ-008 Port 0 grant SHALL drive ram_ren=1 and ram_raddr=m0_addr.
REQ-009 A port 1 read grant SHALL drive ram_ren=1 and ram_raddr=m1_addr.
REQ-010 A port 1 write grant SHALL drive ram_wen=1, ram_waddr=m1_addr and ram_wdata=m1_wdata.
REQ-011 With no grant, ram_wen and ram_ren SHALL be 0, and the address and data outputs SHALL be 0.
REQ-012 The pending-read FSM SHALL have states IDLE, RD0 and RD1.
- Next state is RD0 on a port 0 grant, RD1 on a port 1 read grant, else IDLE.
- The state is evaluated every cycle, so back-to-back reads from either port are supported.
REQ-013 mX_rvalid SHALL be 1 exactly when the state is RDX, i.e. one cycle after the grant.
REQ-014 mX_rdata SHALL equal ram_rdata when mX_rvalid=1 and SHALL be 0 otherwise.
REQ-015 A port 1 write SHALL never produce an rvalid pulse.
REQ-016 A port whose request is not granted SHALL hold its request and address stable until granted.
REQ-017 The arbiter SHALL NOT queue requests.
REQ-018 Grants SHALL be independent of the pending-read state; issuing in the cycle a prior read returns is legal.
REQ-019 Two 16-bit saturating counters, gnt0_cnt and gnt1_cnt, SHALL count grants per port for debug.
- Each counter stops at 16'hFFFF.
- The counters are internal and not on the port list.

Reset
REQ-020 While reset=1, state SHALL be IDLE and starve_cnt, gnt0_cnt and gnt1_cnt SHALL be 0, asynchronously.
REQ-021 While reset=1, all grant, rvalid and ram enable outputs SHALL be 0.
REQ-022 A read granted in the cycle before reset asserts SHALL produce no rvalid after reset deasserts.
REQ-023 The first grant after reset SHALL follow the default priority.

Verification
REQ-024 Port 0 only, read at 0x10 with RAM word 0xDEADBEEF -> m0_gnt=1 at cycle T, m0_rvalid=1 and m0_rdata=0xDEADBEEF at T+1, m1 outputs 0.
REQ-025 Port 1 write 0x20<-0x12345678 then port 1 read 0x20 -> ram_wen pulse with no m1_rvalid, then m1_rvalid at read grant+1 with data 0x12345678.
REQ-026 Both ports request continuously, STARVE_LIMIT=4 -> grant pattern m1,m1,m1,m1,m0, repeating; m0 is never starved for more than 4 cycles.
REQ-027 Back-to-back grants m0 then m1 read -> m0_rvalid at T+1 and m1_rvalid at T+2, never overlapping; ram_wen&ram_ren never 1.
REQ-028 Reset asserted mid-cycle right after an m1 read grant -> outputs 0 immediately, no m1_rvalid after release, starve_cnt=0.
